// File: rtl/ahb_sram_banked.sv
// ahb_sram_banked: AHB slave over word-interleaved single-port SRAM banks.
// Define SRAMC_ERR_RESP_EN for ERROR responses to out-of-range/illegal-size accesses.
module ahb_sram_banked #(
  parameter int NUM_BANKS  = 2,
  parameter int BANK_DEPTH = 8192
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic        hready,
  input  logic [1:0]  htrans,
  input  logic [1:0]  hsize,
  input  logic [3:0]  hburst,
  input  logic        hwrite,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic [1:0]  hresp,
  output logic        hready_o
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int BIW    = (BANK_W > 0) ? BANK_W : 1;
  localparam int DW     = $clog2(BANK_DEPTH);
  localparam int MEM_AW = 2 + BANK_W + DW;

`ifdef SRAMC_ERR_RESP_EN
  localparam logic [1:0] ERR_RESP = 2'b01;
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_CONFLICT, S_ERR1, S_ERR2
  } state_e;

  state_e state_q, state_d;

  logic [31:0]    mem [NUM_BANKS][BANK_DEPTH];
  logic [BIW-1:0] wbank_q;
  logic [DW-1:0]  wword_q;
  logic [3:0]     wstrb_q;
  logic [31:0]    hrdata_q;

  logic [BIW-1:0] a_bank;
  logic [DW-1:0]  a_word;
  logic [3:0]     a_strb;
  logic           a_err;
  logic           acc;
  logic           conflict;
  logic           unused_ok;

  assign a_bank = haddr[2 +: BIW] & BIW'(NUM_BANKS - 1);
  assign a_word = haddr[2 + BANK_W +: DW];

`ifdef SRAMC_ERR_RESP_EN
  assign a_err = ((haddr >> MEM_AW) != 32'd0) || (hsize == 2'd3);
`else
  assign a_err = 1'b0;
`endif

  assign unused_ok = ^{hburst, haddr, htrans[0]};

  always_comb begin
    a_strb = 4'b1111;
    unique case (1'b1)
      (hsize == 2'd0): a_strb = 4'b0001 << haddr[1:0];
      (hsize == 2'd1): a_strb = haddr[1] ? 4'b1100 : 4'b0011;
      default:         a_strb = 4'b1111;
    endcase
  end

  assign acc = hsel & hready & htrans[1] & hready_o;

  // a read hitting the bank the pending write targets must wait a cycle
  assign conflict = (state_q == S_WDATA) & hsel & htrans[1] &
                    ~hwrite & (a_bank == wbank_q);

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = S_IDLE;
    unique case (state_q)
      S_ERR1: state_d = S_ERR2;
      default: begin
        if (conflict)           state_d = S_CONFLICT;
        else if (acc && a_err)  state_d = S_ERR1;
        else if (acc && hwrite) state_d = S_WDATA;
        else                    state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    hready_o = 1'b1;
    hresp    = 2'b00;
    unique case (state_q)
      S_WDATA: hready_o = ~conflict;
      S_ERR1: begin
        hready_o = 1'b0;
        hresp    = ERR_RESP;
      end
      S_ERR2:  hresp = ERR_RESP;
      default: hready_o = 1'b1;
    endcase
  end

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      wbank_q  <= '0;
      wword_q  <= '0;
      wstrb_q  <= '0;
      hrdata_q <= '0;
    end else begin
      if (acc && hwrite && !a_err) begin
        wbank_q <= a_bank;
        wword_q <= a_word;
        wstrb_q <= a_strb;
      end
      if (acc && !hwrite && !a_err) begin
        hrdata_q <= mem[a_bank][a_word];
      end
    end
  end

  // reset low at the commit edge drops the pending write
  always_ff @(posedge hclk) begin
    if (hreset && state_q == S_WDATA) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem[wbank_q][wword_q][8*i +: 8] <= hwdata[8*i +: 8];
        end
      end
    end
  end

  assign hrdata = hrdata_q;

endmodule
